pr_stream_ctrl: RTL and testbench

- Upstream controller for one partial-reconfiguration IP instance (pr_ip).
- On a start request it:
  - freezes the PR region;
  - pulses pr_start;
  - streams a fixed-length 16-bit bitstream from a source valid/ready port into the IP's data/data_valid/data_ready port;
  - monitors the IP status;
  - releases freeze on success.
- One instance per pr_ip in top; replaces the tied-off pr_start/data/data_valid and drives freeze.

---
 rtl/pr_stream_ctrl_pkg.sv | 31 +++
 rtl/pr_stream_ctrl_timer.sv | 32 +++
 rtl/pr_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pr_stream_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_stream_ctrl_pkg.sv
// Shared types and constants for the partial-reconfiguration stream controller:
// FSM state encoding, pr_ip status codes and the timeout error code.
package pr_stream_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FREEZE,
    START,
    WAIT_ACK,
    STREAM,
    WAIT_RESULT,
    RELEASE,
    DONE,
    ERROR
  } state_t;

  localparam logic [2:0] ST_POWERUP     = 3'b000;
  localparam logic [2:0] ST_PR_ERR      = 3'b001;
  localparam logic [2:0] ST_CRC_ERR     = 3'b010;
  localparam logic [2:0] ST_INCOMPAT    = 3'b011;
  localparam logic [2:0] ST_IN_PROGRESS = 3'b100;
  localparam logic [2:0] ST_SUCCESS     = 3'b101;

  localparam logic [2:0] ERR_TIMEOUT    = 3'b111;

  // Reserved codes 110/111 fall through as "no event", same as POWERUP.
  function automatic logic is_fail(input logic [2:0] status);
    return status inside {ST_PR_ERR, ST_CRC_ERR, ST_INCOMPAT};
  endfunction

endpackage

// File: rtl/pr_stream_ctrl_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Shared by the freeze settle phases and, when enabled, the watchdog.
module pr_stream_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pr_stream_ctrl.sv
// Upstream controller for one pr_ip: freeze, pr_start pulse, bitstream pass-through,
// status monitoring and freeze release. Optional watchdog: PR_STREAM_CTRL_TIMEOUT_EN.
module pr_stream_ctrl
  import pr_stream_ctrl_pkg::*;
#(
  parameter int NUM_WORDS      = 1024,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        pr_start,
  output logic [15:0] pr_data,
  output logic        pr_data_valid,
  input  logic        pr_data_ready,
  input  logic [2:0]  pr_status,
  output logic        freeze,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);

  localparam int WC_W = $clog2(NUM_WORDS + 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
`ifdef PR_STREAM_CTRL_TIMEOUT_EN
  localparam int TW = 32;
`else
  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`endif
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  if ((NUM_WORDS < 1) || (SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("pr_stream_ctrl: NUM_WORDS, SETTLE_CYCLES and TIMEOUT_CYCLES must all be >= 1");
  end

  state_t          state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            freeze_q, freeze_d;
  logic            pr_start_q, pr_start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            streaming, xfer, monitoring;

  assign streaming  = (state_q == STREAM);
  assign xfer       = streaming && src_valid && pr_data_ready;
  assign monitoring = state_q inside {WAIT_ACK, STREAM, WAIT_RESULT};

  pr_stream_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    err_code_d = err_code_q;
    tmr_load   = 1'b0;
    tmr_val    = SETTLE_LOAD;
    tmr_dec    = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = FREEZE;
          wcnt_d     = '0;
          err_code_d = '0;
          tmr_load   = 1'b1;
        end
      end
      FREEZE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = START;
      end
      START: begin
        state_d = WAIT_ACK;
`ifdef PR_STREAM_CTRL_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
      end
      WAIT_ACK: begin
        if (pr_status == ST_IN_PROGRESS) state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) state_d = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (pr_status == ST_SUCCESS) begin
          state_d  = RELEASE;
          tmr_load = 1'b1;
        end
      end
      RELEASE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort paths override whatever the state logic chose above.
    if (monitoring) begin
`ifdef PR_STREAM_CTRL_TIMEOUT_EN
      tmr_dec = 1'b1;
      if (tmr_zero) begin
        state_d    = ERROR;
        err_code_d = ERR_TIMEOUT;
      end
`endif
      if (is_fail(pr_status)) begin
        state_d    = ERROR;
        err_code_d = pr_status;
      end
    end

    freeze_d   = !(state_d inside {IDLE, DONE});
    busy_d     = !(state_d inside {IDLE, DONE, ERROR});
    pr_start_d = (state_d == START);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      err_code_q <= '0;
      freeze_q   <= 1'b0;
      pr_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      err_code_q <= err_code_d;
      freeze_q   <= freeze_d;
      pr_start_q <= pr_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Data path is a gated pass-through so a word moves in the same cycle it is offered.
  assign pr_data       = streaming ? src_data : 16'h0000;
  assign pr_data_valid = streaming && src_valid;
  assign src_ready     = streaming && pr_data_ready;

  assign freeze   = freeze_q;
  assign pr_start = pr_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_pr_stream_ctrl.sv
// Directed sequence with randomized source gaps/sink backpressure, checked against
// queue-based expectations of the delivered bitstream and cycle-count arithmetic.
module tb_pr_stream_ctrl;
  import pr_stream_ctrl_pkg::*;

  localparam int NW = 4;
  localparam int SC = 2;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_data = 16'h0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic        pr_start;
  logic [15:0] pr_data;
  logic        pr_data_valid;
  logic        pr_data_ready = 1'b0;
  logic [2:0]  pr_status = ST_POWERUP;
  logic        freeze, busy, done, error;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  pr_stream_ctrl #(
    .NUM_WORDS     (NW),
    .SETTLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .pr_start     (pr_start),
    .pr_data      (pr_data),
    .pr_data_valid(pr_data_valid),
    .pr_data_ready(pr_data_ready),
    .pr_status    (pr_status),
    .freeze       (freeze),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  int          total = 0;
  int          bad = 0;
  logic [15:0] words[$];
  logic [15:0] rx[$];
  int          rx_cyc[$];
  int          src_idx = 0;
  int          gap_pct = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: held low
  int          cyc = 0;
  int          ps_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe transfers before the edge, then drive the next source/sink values.
  task automatic tick();
    logic sfire, pfire;
    @(negedge clk);
    sfire = src_valid && src_ready;
    pfire = pr_data_valid && pr_data_ready;
    if (pr_data_valid) check("pass_data", pr_data, src_data);
    check("xfer_pair", pfire, sfire);
    if (pfire) begin
      rx.push_back(pr_data);
      rx_cyc.push_back(cyc);
    end
    if (pr_start) ps_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (sfire) src_idx++;
    if (!(src_valid && !sfire)) begin
      src_valid = (src_idx < words.size()) && (int'($urandom_range(0, 99)) >= gap_pct);
      src_data  = (src_idx < words.size()) ? words[src_idx] : 16'h0;
    end
    case (rdy_mode)
      0:       pr_data_ready = 1'b1;
      1:       pr_data_ready = ~pr_data_ready;
      2:       pr_data_ready = 1'($urandom_range(0, 1));
      default: pr_data_ready = 1'b0;
    endcase
    #1;
  endtask

  task automatic load_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    rx.delete();
    rx_cyc.delete();
    src_idx   = 0;
    src_valid = 1'b0;
  endtask

  task automatic kick(input string tag);
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_freeze_rise"}, freeze, 1'b1);
    check({tag, "_busy_rise"}, busy, 1'b1);
    lat = 1;
    while (!pr_start && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_pr_start_lat"}, lat, SC + 1);
  endtask

  task automatic wait_rx(input string tag, input int n, input int lim);
    int k = 0;
    while (rx.size() < n && k < lim) begin
      tick();
      k++;
    end
    check({tag, "_rx_timeout"}, rx.size() >= n, 1'b1);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, rx.size(), NW);
    for (int i = 0; i < NW && i < rx.size(); i++) check({tag, "_word"}, rx[i], words[i]);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int ps_before;

    // Reset state
    #23;
    check("rst_freeze", freeze, 1'b0);
    check("rst_pr_start", pr_start, 1'b0);
    check("rst_pdv", pr_data_valid, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_code", err_code, 3'b000);
    check("rst_pr_data", pr_data, 16'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Nominal: always valid, always ready
    rdy_mode = 0;
    gap_pct  = 0;
    load_words(NW);
    kick("t1");
    pr_status = ST_IN_PROGRESS;
    tick();
    check("t1_pr_start_one_cycle", pr_start, 1'b0);
    wait_rx("t1", NW, 50);
    cmp_stream("t1");
    if (rx_cyc.size() == NW) check("t1_back_to_back", rx_cyc[NW-1] - rx_cyc[0], NW - 1);
    check("t1_src_ready_after", src_ready, 1'b0);
    check("t1_pdv_after", pr_data_valid, 1'b0);
    tick();
    tick();
    pr_status = ST_SUCCESS;
    n = 0;
    while (freeze && n < 50) begin
      tick();
      n++;
    end
    check("t1_freeze_fall_lat", n, SC + 1);
    check("t1_done", done, 1'b1);
    check("t1_error", error, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_total_words", rx.size(), NW);

    // Toggling ready, gapped valid, surplus source words
    rdy_mode  = 1;
    gap_pct   = 40;
    pr_status = ST_POWERUP;
    load_words(NW + 2);
    kick("t2");
    pr_status = ST_IN_PROGRESS;
    wait_rx("t2", NW, 200);
    for (int i = 0; i < 5; i++) tick();
    cmp_stream("t2");
    check("t2_src_consumed", src_idx, NW);
    check("t2_src_ready_after", src_ready, 1'b0);
    check("t2_pdv_after", pr_data_valid, 1'b0);
    pr_status = ST_SUCCESS;
    wait_done("t2");

    // CRC error after word 2
    rdy_mode  = 0;
    gap_pct   = 0;
    pr_status = ST_POWERUP;
    load_words(NW);
    kick("t3");
    pr_status = ST_IN_PROGRESS;
    wait_rx("t3", 2, 50);
    pr_status     = ST_CRC_ERR;
    rdy_mode      = 3;
    pr_data_ready = 1'b0;
    tick();
    check("t3_error", error, 1'b1);
    check("t3_err_code", err_code, ST_CRC_ERR);
    check("t3_freeze_held", freeze, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_done", done, 1'b0);
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) tick();
    check("t3_src_ready_stopped", src_ready, 1'b0);
    check("t3_pdv_stopped", pr_data_valid, 1'b0);
    check("t3_no_more_xfers", rx.size(), 2);
    check("t3_freeze_still", freeze, 1'b1);

    // Restart from ERROR
    pr_status = ST_POWERUP;
    load_words(NW);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3r_error_clr", error, 1'b0);
    check("t3r_err_code_clr", err_code, 3'b000);
    check("t3r_freeze", freeze, 1'b1);
    check("t3r_busy", busy, 1'b1);
    n = 1;
    while (!pr_start && n < 100) begin
      tick();
      n++;
    end
    check("t3r_pr_start_lat", n, SC + 1);

    // start pulsed during STREAM is ignored
    pr_status = ST_IN_PROGRESS;
    rdy_mode  = 2;
    gap_pct   = 20;
    wait_rx("t4", 2, 100);
    ps_before = ps_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx("t4", NW, 200);
    for (int i = 0; i < 3; i++) tick();
    cmp_stream("t4");
    check("t4_no_restart_pulse", ps_cnt, ps_before);
    check("t4_busy", busy, 1'b1);
    check("t4_freeze", freeze, 1'b1);
    pr_status = ST_SUCCESS;
    wait_done("t4");

    // Asynchronous reset in STREAM
    rdy_mode  = 0;
    gap_pct   = 0;
    pr_status = ST_POWERUP;
    load_words(NW);
    kick("t5");
    pr_status = ST_IN_PROGRESS;
    wait_rx("t5", 1, 50);
    check("t5_in_stream_pdv", pr_data_valid, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("t5_rst_freeze", freeze, 1'b0);
    check("t5_rst_pdv", pr_data_valid, 1'b0);
    check("t5_rst_src_ready", src_ready, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    pr_status = ST_POWERUP;
    tick();
    check("t5_idle_busy", busy, 1'b0);
    check("t5_idle_freeze", freeze, 1'b0);
    check("t5_idle_done", done, 1'b0);
    check("t5_idle_error", error, 1'b0);
    load_words(NW);
    kick("t6");

`ifdef PR_STREAM_CTRL_TIMEOUT_EN
    // Watchdog: status stuck at POWERUP in WAIT_ACK
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    check("t7_timeout_lat", n, TO + 1);
    check("t7_err_code", err_code, ERR_TIMEOUT);
    check("t7_freeze", freeze, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
